// File: rtl/mskaes_mixcol_fwd_stream.sv
// Masked forward AES MixColumns, one shared 32-bit column per beat, registered output
// with valid/ready handshake, column counter and final-round bypass.
module mskaes_mixcol_fwd_stream #(
  parameter int d = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_bypass,
  input  logic [32*d-1:0] in_col,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*d-1:0] out_col,
  output logic [1:0]      out_idx,
  output logic            out_last
);

  // Each byte k occupies in_col[8*d*k +: 8*d]; bit i of share s sits at d*i+s inside it.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [32*d-1:0] mix_shares(input logic [32*d-1:0] c);
    logic [7:0]      b [4];
    logic [7:0]      a [4];
    logic [32*d-1:0] r;
    r = '0;
    for (int s = 0; s < d; s++) begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 8; i++) begin
          b[k][i] = c[8*d*k + d*i + s];
        end
      end
      a[0] = xtime(b[0]) ^ xtime(b[1]) ^ b[1] ^ b[2] ^ b[3];
      a[1] = b[0] ^ xtime(b[1]) ^ xtime(b[2]) ^ b[2] ^ b[3];
      a[2] = b[0] ^ b[1] ^ xtime(b[2]) ^ xtime(b[3]) ^ b[3];
      a[3] = xtime(b[0]) ^ b[0] ^ b[1] ^ b[2] ^ xtime(b[3]);
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 8; i++) begin
          r[8*d*k + d*i + s] = a[k][i];
        end
      end
    end
    return r;
  endfunction

  logic            out_valid_q, out_valid_d;
  logic [32*d-1:0] out_col_q, out_col_d;
  logic [1:0]      out_idx_q, out_idx_d;
  logic [1:0]      col_q, col_d;
  logic            byp_q, byp_d;
  logic            accept;
  logic            pop;
  logic            use_byp;

  // Handshake: a beat moves on a side when valid and ready are both high at the
  // rising edge; the output beat is held unchanged until out_valid & out_ready.
  assign in_ready = ~clear & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid_q & out_ready;
  // Column 0 decides bypass for the whole state; later columns reuse the latch.
  assign use_byp  = (col_q == 2'd0) ? in_bypass : byp_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_idx_d   = out_idx_q;
    col_d       = col_q;
    byp_d       = byp_q;
    if (clear) begin
      out_valid_d = 1'b0;
      col_d       = 2'd0;
      byp_d       = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_col_d   = use_byp ? in_col : mix_shares(in_col);
      out_idx_d   = col_q;
      col_d       = col_q + 2'd1;
      byp_d       = use_byp;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_idx_q   <= 2'd0;
      col_q       <= 2'd0;
      byp_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_idx_q   <= out_idx_d;
      col_q       <= col_d;
      byp_q       <= byp_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_valid_q & (out_idx_q == 2'd3);

endmodule

// File: tb/tb_mskaes_mixcol_fwd_stream.sv
// Bench for mskaes_mixcol_fwd_stream: GF(2^8) matrix model, scoreboard queue,
// directed AES vectors, backpressure, clear and asynchronous reset.
module tb_mskaes_mixcol_fwd_stream;
  localparam int D = 2;
  localparam int W = 32 * D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_bypass = 1'b0;
  logic [W-1:0] in_col = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_col;
  logic [1:0]   out_idx;
  logic         out_last;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int rdy_cnt = 0;

  logic [W+1:0] exp_q[$];
  logic [31:0]  got_q[$];
  logic [1:0]   got_idx[$];
  logic [1:0]   m_col = 2'd0;
  logic         m_byp = 1'b0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_col;
  logic [1:0]   prev_idx;

  mskaes_mixcol_fwd_stream #(.d(D)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_bypass(in_bypass), .in_col(in_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Column word written b0..b3 from the most significant byte down.
  function automatic logic [31:0] mix(input logic [31:0] w);
    logic [7:0] m [4][4];
    logic [7:0] b [4];
    logic [31:0] r;
    m[0] = '{8'd2, 8'd3, 8'd1, 8'd1};
    m[1] = '{8'd1, 8'd2, 8'd3, 8'd1};
    m[2] = '{8'd1, 8'd1, 8'd2, 8'd3};
    m[3] = '{8'd3, 8'd1, 8'd1, 8'd2};
    for (int c = 0; c < 4; c++) b[c] = w[8*(3-c) +: 8];
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        r[8*(3-row) +: 8] = r[8*(3-row) +: 8] ^ gmul(m[row][c], b[c]);
    return r;
  endfunction

  function automatic logic [W-1:0] pack(input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] w [D];
    logic [W-1:0] r;
    w[0] = w0;
    w[1] = w1;
    r = '0;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++)
        for (int s = 0; s < D; s++)
          r[16*k + 2*i + s] = w[s][8*(3-k) + i];
    return r;
  endfunction

  function automatic logic [31:0] unpack(input logic [W-1:0] c, input int s);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++)
        r[8*(3-k) + i] = c[16*k + 2*i + s];
    return r;
  endfunction

  function automatic logic [W-1:0] mask(input logic [31:0] x);
    logic [31:0] m;
    m = $urandom;
    return pack(x ^ m, m);
  endfunction

  // Scoreboard: model the one-deep output register and compare every cycle.
  always @(negedge clk) begin
    logic m_valid;
    logic acc;
    logic [W+1:0] e;
    if (rst) begin
      exp_q.delete();
      m_col = 2'd0;
      m_byp = 1'b0;
      stall_prev = 1'b0;
    end else begin
      m_valid = (exp_q.size() != 0);
      chk("out_valid", W'(out_valid), W'(m_valid));
      chk("in_ready", W'(in_ready), W'(!clear && (!m_valid || out_ready)));
      if (stall_prev) begin
        chk("stall_col", out_col, prev_col);
        chk("stall_idx", W'(out_idx), W'(prev_idx));
      end
      if (m_valid) begin
        e = exp_q[0];
        chk("out_col", out_col, e[W-1:0]);
        chk("out_idx", W'(out_idx), W'(e[W+1:W]));
        chk("out_last", W'(out_last), W'(e[W+1:W] == 2'd3));
      end else begin
        chk("out_last_idle", W'(out_last), '0);
      end
      acc = in_valid && !clear && (!m_valid || out_ready);
      if (m_valid && out_ready) begin
        void'(exp_q.pop_front());
        got_q.push_back(unpack(out_col, 0) ^ unpack(out_col, 1));
        got_idx.push_back(out_idx);
      end
      if (clear) begin
        exp_q.delete();
        m_col = 2'd0;
        m_byp = 1'b0;
      end else if (acc) begin
        if (m_col == 2'd0) m_byp = in_bypass;
        if (m_byp) exp_q.push_back({m_col, in_col});
        else exp_q.push_back({m_col, pack(mix(unpack(in_col, 0)), mix(unpack(in_col, 1)))});
        m_col = m_col + 2'd1;
      end
      stall_prev = m_valid && !out_ready && !clear;
      prev_col = out_col;
      prev_idx = out_idx;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (rdy_cnt == 0);
          rdy_cnt = (rdy_cnt == 2) ? 0 : rdy_cnt + 1;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [W-1:0] c, input logic b);
    int n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_col = c;
    in_bypass = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    chk("send_timeout", W'(acc), W'(1));
    in_valid = 1'b0;
    in_bypass = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", W'(exp_q.size()), '0);
  endtask

  task automatic fips_state();
    logic [31:0] st [4];
    logic [31:0] rs [4];
    st = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
    rs = '{32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c};
    got_q.delete();
    got_idx.delete();
    rdy_mode = 0;
    for (int k = 0; k < 4; k++) send(mask(st[k]), 1'b0);
    drain();
    chk("fips_count", W'(got_q.size()), W'(4));
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      chk("fips_col", W'(got_q[k]), W'(rs[k]));
      chk("fips_idx", W'(got_idx[k]), W'(k));
    end
  endtask

  initial begin
    logic [31:0] t1_in [4];
    logic [31:0] t1_out [4];
    t1_in  = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
    t1_out = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};

    for (int k = 0; k < 4; k++) chk("model_mix", W'(mix(t1_in[k])), W'(t1_out[k]));
    chk("model_pack", pack(32'h01000000, 32'h0), W'(64'h1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_col", out_col, '0);
    chk("rst_idx", W'(out_idx), '0);
    chk("rst_last", W'(out_last), '0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Unmasked-equivalent vectors, share 1 all zero.
    got_q.delete();
    for (int k = 0; k < 4; k++) send(pack(t1_in[k], 32'h0), 1'b0);
    drain();
    chk("t1_count", W'(got_q.size()), W'(4));
    for (int k = 0; k < 4 && k < got_q.size(); k++) chk("t1_col", W'(got_q[k]), W'(t1_out[k]));

    fips_state();

    // Bypass on column 0 only, then a normal state, then bypass asserted late (ignored).
    for (int k = 0; k < 4; k++) send(mask($urandom), k == 0);
    for (int k = 0; k < 4; k++) send(mask($urandom), 1'b0);
    for (int k = 0; k < 4; k++) send(mask($urandom), k != 0);
    drain();

    // Backpressure with out_ready 1,0,0 repeating.
    rdy_cnt = 0;
    rdy_mode = 1;
    for (int k = 0; k < 8; k++) send(mask($urandom), 1'b0);
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Clear with column 1 pending and an input offered during the clear cycle.
    send(mask(32'h11223344), 1'b0);
    send(mask(32'h55667788), 1'b0);
    rdy_mode = 2;
    clear = 1'b1;
    in_valid = 1'b1;
    in_col = mask(32'h99aabbcc);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    rdy_mode = 0;
    chk("clear_drop", W'(out_valid), '0);
    @(posedge clk);
    #1;
    got_idx.delete();
    send(mask(32'hdb135345), 1'b0);
    drain();
    chk("clear_restart_cnt", W'(got_idx.size()), W'(1));
    if (got_idx.size() != 0) chk("clear_restart_idx", W'(got_idx[0]), '0);
    for (int k = 0; k < 3; k++) send(mask($urandom), 1'b0);
    drain();

    // Asynchronous reset mid-cycle with a stalled output beat.
    rdy_mode = 2;
    send(mask(32'hcafef00d), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", W'(out_valid), '0);
    chk("arst_col", out_col, '0);
    chk("arst_idx", W'(out_idx), '0);
    @(posedge clk);
    #3 rst = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    fips_state();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
